// File: rtl/uart_rx_frame_monitor.sv
// uart_rx_frame_monitor
// 16x-oversampling UART receive checker: 2-flop RX synchroniser, baud tick
// divider, frame decoder FSM (start/data/[parity]/stop), and a first-word-
// fall-through byte FIFO drained by a valid/ready handshake.
// Optional feature: define UART_MON_PARITY_EN to expect one parity bit per
// frame (sense selected by PARITY_ODD). Without it PARITY_ERR never pulses.
module uart_rx_frame_monitor #(
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter bit          DATA_BITS8 = 1'b1,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int          FIFO_DEPTH = 4,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                 PCLK,
    input  logic                 PRESETN,
    input  logic                 RX,
    output logic [7:0]           DATA,
    output logic                 DATA_VALID,
    input  logic                 DATA_READY,
    output logic                 PARITY_ERR,
    output logic                 FRAMING_ERR,
    output logic                 OVERFLOW,
    output logic [CNT_WIDTH-1:0] FRAME_CNT,
    output logic                 BUSY
);

    localparam int         AW       = $clog2(FIFO_DEPTH);
    localparam logic [2:0] LAST_BIT = DATA_BITS8 ? 3'd7 : 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_WAIT_HI = 3'd5
    } state_t;

    // Expected parity bit for a byte: even sense gives XOR of data, odd inverts it.
    function automatic logic parity_of(input logic [7:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic           rx_meta_r;
    logic           rx_sync_r;
    logic [12:0]    tick_cnt_r;
    logic           tick_s;

    state_t         state_r;
    state_t         state_nx;
    logic [3:0]     ph_r;
    logic [3:0]     ph_nx;
    logic [2:0]     bit_r;
    logic [2:0]     bit_nx;
    logic [7:0]     shift_r;
    logic [7:0]     shift_nx;
    logic           par_mismatch_s;
    logic           push_nx;
    logic           ferr_nx;
    logic           perr_nx;

    logic           push_req_r;
    logic [7:0]     push_data_r;
    logic           framing_err_r;
    logic           parity_err_r;
    logic           busy_r;

    logic [7:0]     mem_r [FIFO_DEPTH];
    logic [AW:0]    wptr_r;
    logic [AW:0]    rptr_r;
    logic [AW:0]    wptr_nx;
    logic [AW:0]    rptr_nx;
    logic           pop_s;
    logic           full_s;
    logic           push_ok_s;
    logic           overflow_nx;
    logic [7:0]     data_nx;
    logic [7:0]     data_r;
    logic           data_valid_r;
    logic           overflow_r;
    logic [CNT_WIDTH-1:0] frame_cnt_r;

`ifdef UART_MON_PARITY_EN
    logic           par_bit_r;
    logic           par_bit_nx;
`else
    logic           parity_odd_unused_s;
    // Parity sense has no effect when frames carry no parity bit.
    assign parity_odd_unused_s = PARITY_ODD;
`endif

    // ------------------------------------------------------------------
    // RX synchroniser and baud tick
    // ------------------------------------------------------------------

    // Two-flop synchroniser; idles high so reset does not look like a start bit.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Tick fires on the cycle the down-counter sits at zero.
    always_comb begin
        tick_s = (tick_cnt_r == 13'd0);
    end

    // Free-running 16x tick divider, period BAUD_VALUE+1 clocks.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            tick_cnt_r <= BAUD_VALUE;
        end else if (tick_s) begin
            tick_cnt_r <= BAUD_VALUE;
        end else begin
            tick_cnt_r <= tick_cnt_r - 13'd1;
        end
    end

    // ------------------------------------------------------------------
    // Frame decoder
    // ------------------------------------------------------------------

    // Parity check of the assembled byte against the sampled parity bit.
    always_comb begin
`ifdef UART_MON_PARITY_EN
        par_mismatch_s = (par_bit_r != parity_of(shift_r, PARITY_ODD));
`else
        par_mismatch_s = 1'b0;
`endif
    end

    // Next-state, sub-bit phase, data assembly and event decode; moves on ticks only.
    always_comb begin
        state_nx = state_r;
        ph_nx    = ph_r;
        bit_nx   = bit_r;
        shift_nx = shift_r;
        push_nx  = 1'b0;
        ferr_nx  = 1'b0;
        perr_nx  = 1'b0;
`ifdef UART_MON_PARITY_EN
        par_bit_nx = par_bit_r;
`endif
        if (tick_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_sync_r) begin
                        state_nx = ST_START;
                        ph_nx    = 4'd0;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (ph_r == 4'd7) begin
                        if (rx_sync_r) begin
                            // Line went back high before mid-bit: a glitch.
                            state_nx = ST_IDLE;
                        end else begin
                            state_nx = ST_DATA;
                            ph_nx    = 4'd0;
                            bit_nx   = 3'd0;
                            shift_nx = 8'h00;
                        end
                    end else begin
                        ph_nx = ph_r + 4'd1;
                    end
                end
                ST_DATA: begin
                    ph_nx = ph_r + 4'd1;
                    if (ph_r == 4'd15) begin
                        shift_nx[bit_r] = rx_sync_r;
                        if (bit_r == LAST_BIT) begin
`ifdef UART_MON_PARITY_EN
                            state_nx = ST_PARITY;
`else
                            state_nx = ST_STOP;
`endif
                        end else begin
                            bit_nx = bit_r + 3'd1;
                        end
                    end else begin
                        state_nx = ST_DATA;
                    end
                end
                ST_PARITY: begin
`ifdef UART_MON_PARITY_EN
                    ph_nx = ph_r + 4'd1;
                    if (ph_r == 4'd15) begin
                        par_bit_nx = rx_sync_r;
                        state_nx   = ST_STOP;
                    end else begin
                        state_nx = ST_PARITY;
                    end
`else
                    state_nx = ST_STOP;
`endif
                end
                ST_STOP: begin
                    ph_nx = ph_r + 4'd1;
                    if (ph_r == 4'd15) begin
                        if (!rx_sync_r) begin
                            ferr_nx  = 1'b1;
                            state_nx = ST_WAIT_HI;
                        end else if (par_mismatch_s) begin
                            perr_nx  = 1'b1;
                            state_nx = ST_IDLE;
                        end else begin
                            // Re-arm at mid-stop so back-to-back frames are caught.
                            push_nx  = 1'b1;
                            state_nx = ST_IDLE;
                        end
                    end else begin
                        state_nx = ST_STOP;
                    end
                end
                ST_WAIT_HI: begin
                    if (rx_sync_r) begin
                        state_nx = ST_IDLE;
                    end else begin
                        state_nx = ST_WAIT_HI;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end else begin
            state_nx = state_r;
        end
    end

    // Decoder state, event pulses and the byte handed to the FIFO.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_r       <= ST_IDLE;
            ph_r          <= 4'd0;
            bit_r         <= 3'd0;
            shift_r       <= 8'h00;
            push_req_r    <= 1'b0;
            push_data_r   <= 8'h00;
            framing_err_r <= 1'b0;
            parity_err_r  <= 1'b0;
            busy_r        <= 1'b0;
`ifdef UART_MON_PARITY_EN
            par_bit_r     <= 1'b0;
`endif
        end else begin
            state_r       <= state_nx;
            ph_r          <= ph_nx;
            bit_r         <= bit_nx;
            shift_r       <= shift_nx;
            push_req_r    <= push_nx;
            framing_err_r <= ferr_nx;
            parity_err_r  <= perr_nx;
            busy_r        <= (state_nx != ST_IDLE);
            if (push_nx) begin
                push_data_r <= shift_r;
            end else begin
                push_data_r <= push_data_r;
            end
`ifdef UART_MON_PARITY_EN
            par_bit_r     <= par_bit_nx;
`endif
        end
    end

    // ------------------------------------------------------------------
    // FWFT byte FIFO
    // ------------------------------------------------------------------

    // Push/pop qualification and look-ahead of the next head byte.
    always_comb begin
        pop_s       = data_valid_r & DATA_READY;
        full_s      = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
        push_ok_s   = push_req_r & (~full_s | pop_s);
        overflow_nx = push_req_r & full_s & ~pop_s;
        wptr_nx     = wptr_r + {{AW{1'b0}}, push_ok_s};
        rptr_nx     = rptr_r + {{AW{1'b0}}, pop_s};
        data_nx     = data_r;
        if (wptr_nx == rptr_nx) begin
            // Empty afterwards: keep presenting the last byte.
            data_nx = data_r;
        end else if (push_ok_s && (rptr_nx == wptr_r)) begin
            // New head is the byte being written this cycle.
            data_nx = push_data_r;
        end else begin
            data_nx = mem_r[rptr_nx[AW-1:0]];
        end
    end

    // Storage array; written only on accepted pushes.
    always_ff @(posedge PCLK) begin
        if (push_ok_s) begin
            mem_r[wptr_r[AW-1:0]] <= push_data_r;
        end else begin
            mem_r[wptr_r[AW-1:0]] <= mem_r[wptr_r[AW-1:0]];
        end
    end

    // Pointers, registered head/valid, overflow pulse and frame counter.
    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            wptr_r       <= '0;
            rptr_r       <= '0;
            data_r       <= 8'h00;
            data_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            frame_cnt_r  <= '0;
        end else begin
            wptr_r       <= wptr_nx;
            rptr_r       <= rptr_nx;
            data_r       <= data_nx;
            data_valid_r <= (wptr_nx != rptr_nx);
            overflow_r   <= overflow_nx;
            frame_cnt_r  <= frame_cnt_r + {{(CNT_WIDTH-1){1'b0}}, push_ok_s};
        end
    end

    assign DATA        = data_r;
    assign DATA_VALID  = data_valid_r;
    assign PARITY_ERR  = parity_err_r;
    assign FRAMING_ERR = framing_err_r;
    assign OVERFLOW    = overflow_r;
    assign FRAME_CNT   = frame_cnt_r;
    assign BUSY        = busy_r;

endmodule
